cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
// - Collects results from NUM_SRC functional units and drives them onto the CDB_WIDTH-slot
//   complete broadcast that the reservation stations and the ROB consume.
// - Each source has a small result FIFO, so a unit that loses arbitration stalls only
//   itself, through src_ready.
// - Grants are round-robin with a rotating priority pointer. A source is granted at most
//   once per cycle.
// - A full rewind (flush) discards every buffered result.
// PARAMETERS
// - NUM_SRC     4   number of functional-unit result sources
// - CDB_WIDTH   2   complete slots per cycle (1..NUM_SRC)
// - FIFO_DEPTH  2   entries per source FIFO (power of 2, >=2)
// - PHY_W       6   physical register index width
// - ROB_W       5   ROB index width
// - DATA_W      32  result data width
// PORTS
// - clock        in   1                    clock
// - reset        in   1                    sync, active-high
// - flush        in   1                    rewind-all: drop every buffered and incoming result
// - src_valid    in   NUM_SRC              source s presents a result this cycle
// - src_ready    out  NUM_SRC              source s may push (its FIFO is not full)
// - src_dst      in   NUM_SRC*PHY_W        destination physical register, per source
// - src_rob_idx  in   NUM_SRC*ROB_W        ROB index, per source
// - src_data     in   NUM_SRC*DATA_W       result value, per source
// - cdb_valid    out  CDB_WIDTH            broadcast slot k valid
// - cdb_dst      out  CDB_WIDTH*PHY_W      broadcast physical register
// - cdb_rob_idx  out  CDB_WIDTH*ROB_W      broadcast ROB index
// - cdb_data     out  CDB_WIDTH*DATA_W     broadcast value
// BEHAVIOUR
// - Push:
//   - A push occurs when src_valid[s] & src_ready[s] & !flush.
//   - The entry is written at the clock edge.
//   - src_valid while src_ready=0 is ignored; the bench flags it as a protocol error.
// - src_ready[s]:
//   - Equals (count[s] != FIFO_DEPTH), taken from registered state only.
//   - A full FIFO reads not-ready even in a cycle in which it is popped, so there is no
//     combinational path from grant to ready.
// - Latency: an entry pushed at edge t is eligible at t+1 and is broadcast in cycle t+1
//   at the earliest.
// - Arbitration (combinational from the FIFO heads):
//   - Scan sources rr_ptr, rr_ptr+1, ... mod NUM_SRC.
//   - The first CDB_WIDTH non-empty sources are granted.
//   - Grants pack into slots 0,1,... in scan order.
//   - Unused slots have cdb_valid=0 and all their fields at 0.
// - Pop: each granted source pops its head at the edge. A push and a pop in the same cycle
//   leave count unchanged, and the FIFO stays in order.
// - rr_ptr:
//   - When any grant occurs, rr_ptr <= (last granted source + 1) mod NUM_SRC.
//   - When there is no grant, rr_ptr holds.
// - Flush (synchronous):
//   - cdb_valid is forced to 0 in the flush cycle.
//   - No pops and no pushes occur in that cycle.
//   - At the edge all counts, read pointers and write pointers go to 0 and rr_ptr goes to 0.
//   - src_ready returns to 1 in the next cycle.
// - Reset: same end state as flush. The outputs at and after reset are:
//   - cdb_valid=0, and every cdb field is 0.
//   - src_ready all 1 in the first cycle after reset.
// - Reset asserted mid-operation drops all buffered results. Reset has priority over flush.
// - Pointer arithmetic:
//   - FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally.
//   - count is log2(FIFO_DEPTH)+1 bits.
//   - rr_ptr is log2(NUM_SRC) bits and wraps mod NUM_SRC (NUM_SRC is not necessarily a
//     power of 2).
// CONFIGURATION
// - CDB_BYPASS_EN defined:
//   - An EMPTY source FIFO that is pushed this cycle presents the incoming entry as its
//     head and competes in the same cycle's arbitration.
//   - If the source is granted, the entry is broadcast combinationally and is not written
//     to the FIFO. Latency is 0.
//   - If it is not granted, the entry is written normally.
//   - Bypass never applies during flush.
// - CDB_BYPASS_EN undefined: no src-to-cdb combinational path; the minimum latency is
//   1 cycle.
// TESTING
// - Reset, then idle:
//   - Expect cdb_valid=0 and src_ready=4'b1111.
//   - Expect no valid output for 10 cycles.
// - Single push, source 2 (dst=6'h11, rob=5'h03, data=32'hCAFE) at cycle 1:
//   - Cycle 2: cdb slot0 valid with those values, slot1 invalid, rr_ptr=3.
//   - With CDB_BYPASS_EN the broadcast appears in cycle 1 instead.
// - All 4 sources push one entry each in the same cycle, rr_ptr=0:
//   - Next cycle broadcasts sources 0,1 in slots 0,1.
//   - The cycle after broadcasts sources 2,3.
//   - rr_ptr then equals 0.
// - Backpressure: source 0 pushes every cycle while sources 1..3 push continuously:
//   - src_ready[0] drops to 0 once count[0]==2.
//   - Source 0 is never starved: it is granted at least once in every 2 cycles.
//   - Every pushed rob_idx appears exactly once and in order per source.
// - Flush while FIFOs hold 5 entries and source 1 is pushing:
//   - cdb_valid=0 in the flush cycle.
//   - Next cycle: src_ready all 1, no valid output, and none of the 6 entries is ever
//     broadcast.
// - Reset asserted in the middle of the backpressure scenario:
//   - The next cycle matches the post-reset state.
//   - No stale entry appears afterwards.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Result-bus arbiter: per-source result FIFOs drained onto CDB_WIDTH broadcast slots, round-robin.
// Optional feature: define CDB_BYPASS_EN to let a pushed entry bypass an empty FIFO in the same cycle.
module cdb_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int CDB_WIDTH  = 2,
  parameter int FIFO_DEPTH = 2,
  parameter int PHY_W      = 6,
  parameter int ROB_W      = 5,
  parameter int DATA_W     = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [NUM_SRC-1:0]            src_valid,
  output logic [NUM_SRC-1:0]            src_ready,
  input  logic [NUM_SRC*PHY_W-1:0]      src_dst,
  input  logic [NUM_SRC*ROB_W-1:0]      src_rob_idx,
  input  logic [NUM_SRC*DATA_W-1:0]     src_data,
  output logic [CDB_WIDTH-1:0]          cdb_valid,
  output logic [CDB_WIDTH*PHY_W-1:0]    cdb_dst,
  output logic [CDB_WIDTH*ROB_W-1:0]    cdb_rob_idx,
  output logic [CDB_WIDTH*DATA_W-1:0]   cdb_data
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int RR_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int SLOT_W = $clog2(CDB_WIDTH + 1);
  localparam int SIDX_W = (CDB_WIDTH > 1) ? $clog2(CDB_WIDTH) : 1;
  localparam int ENT_W  = PHY_W + ROB_W + DATA_W;

  logic [ENT_W-1:0] mem      [NUM_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr   [NUM_SRC];
  logic [PTR_W-1:0] wr_ptr   [NUM_SRC];
  logic [CNT_W-1:0] count    [NUM_SRC];
  logic [RR_W-1:0]  rr_ptr;

  logic [ENT_W-1:0] incoming [NUM_SRC];
  logic [ENT_W-1:0] head     [NUM_SRC];
  logic [ENT_W-1:0] slot_ent [CDB_WIDTH];
  logic [CDB_WIDTH-1:0] slot_vld;
  logic [NUM_SRC-1:0] empty, push, cand, grant, pop, wr_en;
  logic               any_grant;
  logic [RR_W-1:0]    rr_next;
  logic [RR_W:0]      scan_pos;
  logic [RR_W-1:0]    scan_idx;
  logic [SLOT_W-1:0]  n_slot;

  // src_ready looks only at registered count, keeping grant off the ready path.
  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      incoming[s]  = {src_dst[s*PHY_W +: PHY_W], src_rob_idx[s*ROB_W +: ROB_W],
                      src_data[s*DATA_W +: DATA_W]};
      src_ready[s] = (count[s] != CNT_W'(FIFO_DEPTH));
      empty[s]     = (count[s] == '0);
      push[s]      = src_valid[s] & src_ready[s] & ~flush;
`ifdef CDB_BYPASS_EN
      cand[s]      = (~empty[s] | push[s]) & ~flush & ~reset;
      head[s]      = empty[s] ? incoming[s] : mem[s][rd_ptr[s]];
`else
      cand[s]      = ~empty[s] & ~flush & ~reset;
      head[s]      = mem[s][rd_ptr[s]];
`endif
    end
  end

  // NOTE: every variable gets a default before the scan so no path leaves one unassigned (no latch).
  always_comb begin
    grant     = '0;
    slot_vld  = '0;
    any_grant = 1'b0;
    rr_next   = rr_ptr;
    n_slot    = '0;
    scan_pos  = '0;
    scan_idx  = '0;
    for (int k = 0; k < CDB_WIDTH; k++) slot_ent[k] = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      scan_pos = {1'b0, rr_ptr} + (RR_W+1)'(i);
      if (scan_pos >= (RR_W+1)'(NUM_SRC)) scan_pos = scan_pos - (RR_W+1)'(NUM_SRC);
      scan_idx = scan_pos[RR_W-1:0];
      if (cand[scan_idx] && (n_slot < SLOT_W'(CDB_WIDTH))) begin
        grant[scan_idx]              = 1'b1;
        slot_vld[n_slot[SIDX_W-1:0]] = 1'b1;
        slot_ent[n_slot[SIDX_W-1:0]] = head[scan_idx];
        n_slot                       = n_slot + 1'b1;
        any_grant                    = 1'b1;
        rr_next = (scan_idx == RR_W'(NUM_SRC - 1)) ? '0 : scan_idx + 1'b1;
      end
    end
  end

  // A granted empty FIFO can only mean a bypassed entry: it is neither popped nor written.
  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      pop[s]   = grant[s] & ~empty[s];
      wr_en[s] = push[s] & ~reset & ~(grant[s] & empty[s]);
    end
  end

  always_comb begin
    for (int k = 0; k < CDB_WIDTH; k++) begin
      cdb_valid[k] = slot_vld[k];
      {cdb_dst[k*PHY_W +: PHY_W], cdb_rob_idx[k*ROB_W +: ROB_W],
       cdb_data[k*DATA_W +: DATA_W]} = slot_ent[k];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        count[s]  <= '0;
        rd_ptr[s] <= '0;
        wr_ptr[s] <= '0;
      end
      rr_ptr <= '0;
    end else begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (wr_en[s]) wr_ptr[s] <= wr_ptr[s] + 1'b1;
        if (pop[s])   rd_ptr[s] <= rd_ptr[s] + 1'b1;
        count[s] <= count[s] + CNT_W'(wr_en[s]) - CNT_W'(pop[s]);
      end
      if (any_grant) rr_ptr <= rr_next;
    end
  end

  // NOTE: FIFO storage is not reset; count gates every read, so stale contents are never visible.
  always_ff @(posedge clock) begin
    for (int s = 0; s < NUM_SRC; s++) begin
      if (wr_en[s]) mem[s][wr_ptr[s]] <= incoming[s];
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with flush/reset.
module tb_cdb_arbiter;

  localparam int NS = 4;
  localparam int W  = 2;
  localparam int D  = 2;

  typedef struct packed {
    logic [5:0]  dst;
    logic [4:0]  rob;
    logic [31:0] data;
  } ent_t;

  logic         clock = 1'b0;
  logic         reset, flush;
  logic [3:0]   src_valid, src_ready;
  logic [23:0]  src_dst;
  logic [19:0]  src_rob_idx;
  logic [127:0] src_data;
  logic [1:0]   cdb_valid;
  logic [11:0]  cdb_dst;
  logic [9:0]   cdb_rob_idx;
  logic [63:0]  cdb_data;

  cdb_arbiter dut (
    .clock(clock), .reset(reset), .flush(flush),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_dst(src_dst), .src_rob_idx(src_rob_idx), .src_data(src_data),
    .cdb_valid(cdb_valid), .cdb_dst(cdb_dst), .cdb_rob_idx(cdb_rob_idx), .cdb_data(cdb_data)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  ent_t q [NS][$];
  int   rr;
  logic [3:0] in_v;
  ent_t       in_e [NS];

  logic [1:0]  s_valid;
  logic [11:0] s_dst;
  logic [9:0]  s_rob;
  logic [63:0] s_data;
  logic [3:0]  s_rdy;

  bit bp_mode;
  bit saw_full0;
  int starve;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic stage(int s, logic [5:0] d, logic [4:0] r, logic [31:0] x);
    if (q[s].size() < D) begin
      in_v[s] = 1'b1;
      in_e[s] = '{dst: d, rob: r, data: x};
    end
  endtask

  task automatic check_pair(string name, int a, int b);
    logic [5:0] da, db;
    da = 6'(32 + a);
    db = 6'(32 + b);
    check(name, {s_valid, s_dst}, {2'b11, db, da});
  endtask

  // One cycle: drive staged inputs, predict and compare at negedge, advance the model.
  task automatic step();
    logic [1:0]  ev;
    logic [11:0] ed;
    logic [9:0]  er;
    logic [63:0] edat;
    logic [3:0]  erdy, pushing, gnt;
    int slot, last;
    bit any, got0;
    for (int s = 0; s < NS; s++) begin
      src_valid[s]              = in_v[s];
      src_dst[s*6 +: 6]         = in_e[s].dst;
      src_rob_idx[s*5 +: 5]     = in_e[s].rob;
      src_data[s*32 +: 32]      = in_e[s].data;
    end
    @(negedge clock);
    for (int s = 0; s < NS; s++) begin
      erdy[s]    = (q[s].size() != D);
      pushing[s] = in_v[s] && erdy[s] && !flush && !reset;
    end
    ev = '0; ed = '0; er = '0; edat = '0; gnt = '0;
    slot = 0; last = 0; any = 0;
    if (!reset && !flush) begin
      for (int i = 0; i < NS; i++) begin
        int s;
        bit c;
        ent_t e;
        s = (rr + i) % NS;
        c = q[s].size() > 0;
        e = c ? q[s][0] : in_e[s];
`ifdef CDB_BYPASS_EN
        if (!c && pushing[s]) c = 1;
`endif
        if (c && slot < W) begin
          ev[slot]            = 1'b1;
          ed[slot*6 +: 6]     = e.dst;
          er[slot*5 +: 5]     = e.rob;
          edat[slot*32 +: 32] = e.data;
          gnt[s] = 1'b1;
          last = s;
          any = 1;
          slot++;
        end
      end
    end
    check("cdb_valid", cdb_valid, ev);
    check("cdb_dst", cdb_dst, ed);
    check("cdb_rob_idx", cdb_rob_idx, er);
    check("cdb_data", cdb_data, edat);
    check("src_ready", src_ready, erdy);
    s_valid = cdb_valid; s_dst = cdb_dst; s_rob = cdb_rob_idx; s_data = cdb_data; s_rdy = src_ready;

    if (bp_mode) begin
      if (src_ready[0] === 1'b0) saw_full0 = 1;
      if (q[0].size() > 0) begin
        got0 = (cdb_valid[0] && cdb_dst[5:4] == 2'd0) || (cdb_valid[1] && cdb_dst[11:10] == 2'd0);
        starve = got0 ? 0 : starve + 1;
        check("src0_not_starved", (starve <= 1), 1);
      end else begin
        starve = 0;
      end
    end

    if (reset || flush) begin
      for (int s = 0; s < NS; s++) q[s].delete();
      rr = 0;
    end else begin
      for (int s = 0; s < NS; s++) begin
        bit was_empty;
        was_empty = (q[s].size() == 0);
        if (gnt[s] && !was_empty) void'(q[s].pop_front());
        if (pushing[s] && !(gnt[s] && was_empty)) q[s].push_back(in_e[s]);
      end
      if (any) rr = (last + 1) % NS;
    end
    in_v = '0;
    @(posedge clock);
    #1;
  endtask

  task automatic stage_bp(ref int seq [NS], input int cyc);
    for (int s = 0; s < NS; s++) begin
      stage(s, {s[1:0], cyc[3:0]}, seq[s][4:0], $urandom);
      if (in_v[s]) seq[s]++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seq [NS];
    int total;
    reset = 1'b1; flush = 1'b0; src_valid = '0;
    src_dst = '0; src_rob_idx = '0; src_data = '0;
    in_v = '0; rr = 0; bp_mode = 0; saw_full0 = 0; starve = 0;
    for (int s = 0; s < NS; s++) begin in_e[s] = '0; seq[s] = 0; end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reset then idle.
    step();
    check("reset_valid", s_valid, 2'b00);
    check("reset_ready", s_rdy, 4'b1111);
    check("reset_fields", {s_dst, s_rob, s_data}, '0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_valid", s_valid, 2'b00);
    end

    // Single push from source 2.
    stage(2, 6'h11, 5'h03, 32'hCAFE);
    step();
`ifndef CDB_BYPASS_EN
    check("single_lat_c1", s_valid, 2'b00);
    step();
`endif
    check("single_valid", s_valid, 2'b01);
    check("single_dst", s_dst, 12'h011);
    check("single_rob", s_rob, 10'h003);
    check("single_data", s_data, 64'h0000_0000_0000_CAFE);

    // rr_ptr is now 3: all four pushing drain as {3,0} then {1,2}.
    for (int s = 0; s < NS; s++) stage(s, 6'(32 + s), 5'(s), 32'(s * 100));
    step();
`ifndef CDB_BYPASS_EN
    step();
`endif
    check_pair("rr3_first", 3, 0);
    step();
    check_pair("rr3_second", 1, 2);

    flush = 1'b1;
    step();
    check("flush_valid_a", s_valid, 2'b00);
    flush = 1'b0;

    // rr_ptr back at 0: {0,1} then {2,3}, then rr_ptr=0 orders {0,3}.
    for (int s = 0; s < NS; s++) stage(s, 6'(32 + s), 5'(s), 32'(s + 7));
    step();
`ifndef CDB_BYPASS_EN
    step();
`endif
    check_pair("all4_first", 0, 1);
    step();
    check_pair("all4_second", 2, 3);
    stage(3, 6'(35), 5'd9, 32'h33);
    stage(0, 6'(32), 5'd8, 32'h30);
    step();
`ifndef CDB_BYPASS_EN
    step();
`endif
    check_pair("rr0_after_wrap", 0, 3);

    // Backpressure: every source pushes whenever ready.
    bp_mode = 1;
    for (int c = 0; c < 40; c++) begin
      stage_bp(seq, c);
      step();
    end
    check("bp_saw_ready0_low", saw_full0, 1'b1);

    // Reset in the middle of backpressure traffic.
    bp_mode = 0;
    stage_bp(seq, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset_valid", s_valid, 2'b00);
    step();
    check("postreset_ready", s_rdy, 4'b1111);
    check("postreset_out", {s_valid, s_dst, s_rob, s_data}, '0);
    for (int i = 0; i < 8; i++) begin
      step();
      check("postreset_idle", s_valid, 2'b00);
    end

    // Flush with five buffered entries while source 1 pushes.
    for (int s = 0; s < NS; s++) stage(s, 6'(16 + s), 5'(20 + s), 32'hF000 + 32'(s));
    step();
    stage(0, 6'h1A, 5'd24, 32'hF0A0);
    stage(2, 6'h1B, 5'd25, 32'hF0B0);
    stage(3, 6'h1C, 5'd26, 32'hF0C0);
    step();
    total = 0;
    for (int s = 0; s < NS; s++) total += q[s].size();
`ifndef CDB_BYPASS_EN
    check("flush_buffered", total, 5);
`endif
    flush = 1'b1;
    stage(1, 6'h1D, 5'd27, 32'hF0D0);
    step();
    flush = 1'b0;
    check("flush_cycle_valid", s_valid, 2'b00);
    step();
    check("postflush_ready", s_rdy, 4'b1111);
    check("postflush_valid", s_valid, 2'b00);
    for (int i = 0; i < 10; i++) begin
      step();
      check("postflush_idle", s_valid, 2'b00);
    end

    // Randomized traffic with occasional flush and reset.
    for (int c = 0; c < 3000; c++) begin
      for (int s = 0; s < NS; s++)
        if ($urandom_range(9) < 6) stage(s, 6'($urandom), 5'($urandom), $urandom);
      flush = ($urandom_range(63) == 0);
      reset = ($urandom_range(499) == 0);
      step();
      flush = 1'b0;
      reset = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
